entity_slot_scheduler: RTL and testbench
========================================

# entity_slot_scheduler

Sits between the game-logic requesters and the picture processing unit. Arbitrates entity-update writes from three requesters, using round-robin order and a valid/ready handshake. Accepted writes are staged in a shadow slot array. The shadow array is committed to the live slot outputs once per frame, at a configurable vertical line, so the PPU never sees a half-updated scene mid-frame.

## Interface
- COMMIT_LINE, 480: value of counter_V at which shadow→live commit occurs (first line of vertical blanking).
- UNUSED_WORD, 18'h3F000: slot value meaning "empty" (entity ID field 4'hF).
- clk  in  1  pixel clock, 25 MHz.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- counter_V  in  10  current VGA line, from the sync generator.
- req_valid  in  3  per-requester write request; bit 0 = player logic, bit 1 = sword logic, bit 2 = dragon logic.
- req_slot_flat  in  12  slot index per requester; bits [4i+3:4i] belong to requester i. Indices 0–7 map to entity_1..8 and 8–14 to dragon_1..7.
- req_data_flat  in  54  18-bit entity word per requester, at bits [18i+17:18i].
- clear_all  in  1  single-cycle pulse; sets every shadow slot to UNUSED_WORD.
- req_ready  out  3  one-hot grant, combinational from req_valid, the pointer and the commit/clear condition.
- slots_flat  out  270  live slots; slot k at bits [18k+17:18k], registered.
- frame_tick  out  1  one-cycle pulse after each commit event, registered.
- dirty  out  1  shadow differs from live (any write or clear since the last commit).
- slot_err  out  1  sticky flag: a write was accepted with slot index 15.

## Operation
- State:
  - shadow[15], live[15]: 18 bits each.
  - rr_ptr: 2 bits, values 0–2.
  - prev_V: 10 bits.
  - dirty, slot_err.
- Commit event (combinational): counter_V == COMMIT_LINE && prev_V != COMMIT_LINE. prev_V <= counter_V every cycle.
- Arbitration:
  - Scan order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first requester with req_valid set gets req_ready.
  - No grant in a cycle where the commit event or clear_all is true.
- Transfer: req_valid[i] && req_ready[i]. On the next edge:
  - shadow[slot] <= data.
  - dirty <= 1.
  - rr_ptr <= (i+1) mod 3.
  - rr_ptr does not change when there is no transfer.
- Slot index 15: the write is accepted (ready given), the data is discarded, slot_err <= 1, and dirty is unchanged.
- clear_all: at the next edge every shadow slot <= UNUSED_WORD and dirty <= 1.
  - If clear_all coincides with the commit event, the commit happens first: live takes the pre-clear shadow, and dirty ends at 1.
- Commit event: at the next edge:
  - live <= shadow, if dirty.
  - dirty <= 0.
  - frame_tick <= 1.
  - frame_tick pulses every frame, including frames where dirty was 0.
- A requester must hold req_valid, slot and data stable until it is granted. Dropping req_valid before the grant withdraws the request.
- Reset (asynchronous assert, clock-synchronous release):
  - shadow and live slots = UNUSED_WORD.
  - rr_ptr = 0, prev_V = 0.
  - dirty = 0, slot_err = 0, frame_tick = 0.
  - req_ready = 0 while reset_n is low.
  - Reset mid-frame discards any staged writes.

## Timing
- Grant latency:
  - 0 cycles (combinational ready) when no other requester is valid and the cycle is not a commit or clear cycle.
  - With all three valid: at most 2 cycles of waiting.
- Write → shadow: 1 edge.
- Commit: live and frame_tick are updated on the edge that samples the commit event, and are visible the following cycle.
- Write-to-display latency: from shadow update to the next commit event (at most one frame).
- slots_flat changes only on commit edges or on reset.
- Throughput: 1 accepted write per cycle, except for commit and clear cycles.

## Test plan
- Reset, then idle for 2 frames:
  - slots_flat is all 18'h3F000.
  - frame_tick pulses exactly once per frame, the cycle after counter_V first reads 480.
  - dirty stays 0.
- Requester 0 writes slot 3 = 18'h0A4_25 at counter_V = 100:
  - ready is granted the same cycle.
  - slots_flat[71:54] stays 3F000 until the edge at line 480, then reads 0A425 (value written as 18'h0A425).
  - dirty goes 1, then returns to 0.
- All three requesters hold valid continuously (slots 0, 1, 2):
  - grants occur in order 0, 1, 2, 0, ….
  - no requester waits more than 2 cycles.
  - after three transfers from an rr_ptr=0 start, rr_ptr = 0.
- Request held valid across the commit cycle:
  - req_ready is 0 on the commit-event cycle.
  - the grant occurs the next cycle, and the write appears at the following frame's commit.
- Write with slot 15 and data 18'h00001:
  - ready is granted and slot_err = 1 (stays set).
  - all live slots are unchanged after commit.
  - dirty is not set by this write.
- clear_all with slot 5 already staged, same cycle as the commit event:
  - live slot 5 takes the staged value.
  - dirty = 1 afterwards.
  - the next commit sets all live slots to 3F000.
- Additional check: reset_n pulsed low mid-line asynchronously → all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/entity_slot_scheduler_if.sv
// Requester-side write bus of the entity slot scheduler: three parallel
// valid/ready channels, each carrying a 4-bit slot index and an 18-bit entity word.
interface entity_slot_scheduler_if;
    logic [2:0]  req_valid;
    logic [11:0] req_slot_flat;
    logic [53:0] req_data_flat;
    logic [2:0]  req_ready;

    modport master (
        output req_valid,
        output req_slot_flat,
        output req_data_flat,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_slot_flat,
        input  req_data_flat,
        output req_ready
    );
endinterface

// File: rtl/entity_slot_scheduler.sv
// Round-robin arbiter for three entity-update requesters. Accepted writes land in a
// shadow slot array, which is copied to the live slots once per frame at COMMIT_LINE
// so the PPU never observes a partially updated scene.
module entity_slot_scheduler #(
    parameter int unsigned COMMIT_LINE = 480,
    parameter logic [17:0] UNUSED_WORD = 18'h3F000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [9:0]                    counter_V,
    input  logic                          clear_all,
    entity_slot_scheduler_if.slave        req,
    output logic [269:0]                  slots_flat,
    output logic                          frame_tick,
    output logic                          dirty,
    output logic                          slot_err
);
    localparam logic [9:0] CommitLine = 10'(COMMIT_LINE);

    logic [17:0] shadow_q [15];
    logic [17:0] shadow_d [15];
    logic [17:0] live_q [15];
    logic [17:0] live_d [15];
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [9:0]  prev_v_q, prev_v_d;
    logic        dirty_q, dirty_d;
    logic        slot_err_q, slot_err_d;
    logic        frame_tick_q, frame_tick_d;

    logic        commit_ev;
    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic [3:0]  w_slot;
    logic [17:0] w_data;

    // Commit fires on the first cycle counter_V reads the commit line.
    assign commit_ev = (counter_V == CommitLine) && (prev_v_q != CommitLine);

    // Rotating-priority grant; scanning from the lowest priority up lets the
    // highest-priority valid requester overwrite earlier picks.
    always_comb begin
        logic [2:0] s;
        logic [1:0] p;
        grant     = '0;
        grant_idx = '0;
        s         = '0;
        p         = '0;
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, rr_ptr_q} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            p = s[1:0];
            if (req.req_valid[p]) begin
                grant     = 3'b001 << p;
                grant_idx = p;
            end
        end
        // Commit and clear cycles own the shadow array, so no write may land then.
        if (commit_ev || clear_all || !reset_n) grant = '0;
    end

    assign req.req_ready = grant;

    // Select the granted requester's slot index and data word.
    always_comb begin
        case (grant_idx)
            2'd1: begin
                w_slot = req.req_slot_flat[7:4];
                w_data = req.req_data_flat[35:18];
            end
            2'd2: begin
                w_slot = req.req_slot_flat[11:8];
                w_data = req.req_data_flat[53:36];
            end
            default: begin
                w_slot = req.req_slot_flat[3:0];
                w_data = req.req_data_flat[17:0];
            end
        endcase
    end

    // Next state: commit reads the pre-clear shadow, then clear, then any write.
    always_comb begin
        shadow_d     = shadow_q;
        live_d       = live_q;
        rr_ptr_d     = rr_ptr_q;
        dirty_d      = dirty_q;
        slot_err_d   = slot_err_q;
        prev_v_d     = counter_V;
        frame_tick_d = commit_ev;
        if (commit_ev) begin
            if (dirty_q) live_d = shadow_q;
            dirty_d = 1'b0;
        end
        if (clear_all) begin
            for (int k = 0; k < 15; k++) shadow_d[k] = UNUSED_WORD;
            dirty_d = 1'b1;
        end
        if (|grant) begin
            rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            if (w_slot == 4'hF) begin
                // Slot 15 is not a real slot: accept, drop the data, flag it.
                slot_err_d = 1'b1;
            end else begin
                for (int k = 0; k < 15; k++) begin
                    if (w_slot == 4'(k)) shadow_d[k] = w_data;
                end
                dirty_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 15; k++) begin
                shadow_q[k] <= UNUSED_WORD;
                live_q[k]   <= UNUSED_WORD;
            end
            rr_ptr_q     <= 2'd0;
            prev_v_q     <= 10'd0;
            dirty_q      <= 1'b0;
            slot_err_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            live_q       <= live_d;
            rr_ptr_q     <= rr_ptr_d;
            prev_v_q     <= prev_v_d;
            dirty_q      <= dirty_d;
            slot_err_q   <= slot_err_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Flatten the live array onto the output bus.
    always_comb begin
        slots_flat = '0;
        for (int k = 0; k < 15; k++) slots_flat[18*k +: 18] = live_q[k];
    end

    assign frame_tick = frame_tick_q;
    assign dirty      = dirty_q;
    assign slot_err   = slot_err_q;
endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Bench for entity_slot_scheduler: directed scenarios plus randomized traffic, all
// checked against a frame-level behavioural model of the shadow/live slot scheme.
`timescale 1ns/1ps
module tb_entity_slot_scheduler;
    localparam logic [17:0] UNUSED = 18'h3F000;
    localparam int CLINE  = 480;
    localparam int NLINES = 525;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [9:0]   counter_V;
    logic         clear_all;
    logic [269:0] slots_flat;
    logic         frame_tick, dirty, slot_err;

    entity_slot_scheduler_if bus ();

    entity_slot_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .counter_V  (counter_V),
        .clear_all  (clear_all),
        .req        (bus.slave),
        .slots_flat (slots_flat),
        .frame_tick (frame_tick),
        .dirty      (dirty),
        .slot_err   (slot_err)
    );

    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [17:0]  m_shadow [15];
    logic [17:0]  m_live [15];
    int           m_ptr;
    bit           m_dirty, m_err, m_tick;
    int           m_prev;
    int           line;
    logic [2:0]   exp_ready, obs_ready;
    logic [269:0] all_unused;

    task automatic model_reset();
        for (int k = 0; k < 15; k++) begin
            m_shadow[k] = UNUSED;
            m_live[k]   = UNUSED;
        end
        m_ptr = 0; m_dirty = 0; m_err = 0; m_tick = 0; m_prev = 0;
    endtask

    function automatic logic [269:0] pack_live();
        logic [269:0] p = '0;
        for (int k = 0; k < 15; k++) p = p | (270'(m_live[k]) << (18 * k));
        return p;
    endfunction

    function automatic logic [17:0] live_slot(input int s);
        return 18'(slots_flat >> (18 * s));
    endfunction

    // Which requester should be granted right now, from the arbitration rules.
    function automatic logic [2:0] model_grant();
        if (!reset_n) return 3'b000;
        if (clear_all || (int'(counter_V) == CLINE && m_prev != CLINE)) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            int r = (m_ptr + k) % 3;
            if (((bus.req_valid >> r) & 3'b001) != 3'b000) return 3'(1 << r);
        end
        return 3'b000;
    endfunction

    task automatic set_line(input int l);
        line = l;
        counter_V = 10'(l);
    endtask

    // One clock: sample ready, apply the edge to the model, advance the line counter.
    task automatic tick();
        logic [2:0]  g;
        logic [11:0] sl;
        logic [53:0] da;
        bit          clr, com;
        int          cv;
        #1;
        obs_ready = bus.req_ready;
        exp_ready = model_grant();
        g   = exp_ready;
        sl  = bus.req_slot_flat;
        da  = bus.req_data_flat;
        clr = clear_all;
        cv  = int'(counter_V);
        com = (cv == CLINE) && (m_prev != CLINE);
        @(posedge clk);
        m_tick = com;
        if (com) begin
            if (m_dirty) m_live = m_shadow;
            m_dirty = 0;
        end
        if (clr) begin
            for (int k = 0; k < 15; k++) m_shadow[k] = UNUSED;
            m_dirty = 1;
        end
        for (int r = 0; r < 3; r++) begin
            if (g[r]) begin
                logic [3:0] s = 4'(sl >> (4 * r));
                if (s == 4'hF) m_err = 1;
                else begin
                    m_shadow[s] = 18'(da >> (18 * r));
                    m_dirty = 1;
                end
                m_ptr = (r + 1) % 3;
            end
        end
        m_prev = cv;
        #1;
        set_line((line + 1) % NLINES);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_slot_flat = 12'h210;
        bus.req_data_flat = '1;
        clear_all = 1'b0;
        set_line(0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (slots_flat !== all_unused) begin failures++; $display("FAIL reset_slots: got %h exp %h", slots_flat, all_unused); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b exp 0", frame_tick); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL reset_dirty: got %b exp 0", dirty); end
        checks++; if (slot_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", slot_err); end
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready: got %b exp 000", bus.req_ready); end
        bus.req_valid = 3'b000;
        reset_n = 1'b1;
    endtask

    task automatic test_idle_frames();
        int ticks = 0;
        for (int c = 0; c < 2 * NLINES; c++) begin
            int prev_line = line;
            tick();
            if (frame_tick === 1'b1) ticks++;
            checks++; if (frame_tick !== (prev_line == CLINE)) begin failures++; $display("FAIL idle_tick line %0d: got %b exp %b", prev_line, frame_tick, prev_line == CLINE); end
            checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL idle_dirty: got %b exp 0", dirty); end
        end
        checks++; if (ticks != 2) begin failures++; $display("FAIL idle_tick_count: got %0d exp 2", ticks); end
        checks++; if (slots_flat !== all_unused) begin failures++; $display("FAIL idle_slots: got %h exp %h", slots_flat, all_unused); end
    endtask

    task automatic test_single_write();
        set_line(100);
        bus.req_valid = 3'b001;
        bus.req_slot_flat = 12'h003;
        bus.req_data_flat = 54'(18'h0A425);
        tick();
        bus.req_valid = 3'b000;
        checks++; if (obs_ready !== 3'b001) begin failures++; $display("FAIL single_ready: got %b exp 001", obs_ready); end
        checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL single_dirty_set: got %b exp 1", dirty); end
        set_line(470);
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (live_slot(3) !== UNUSED) begin failures++; $display("FAIL single_early: got %h exp %h", live_slot(3), UNUSED); end
        end
        tick();
        checks++; if (live_slot(3) !== 18'h0A425) begin failures++; $display("FAIL single_commit: got %h exp 0a425", live_slot(3)); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL single_dirty_clr: got %b exp 0", dirty); end
        checks++; if (slots_flat !== pack_live()) begin failures++; $display("FAIL single_slots: got %h exp %h", slots_flat, pack_live()); end
    endtask

    task automatic test_round_robin();
        int wait_c[3];
        int max_wait = 0;
        set_line(10);
        bus.req_valid = 3'b100;
        bus.req_slot_flat = 12'h210;
        bus.req_data_flat = {18'($urandom), 18'($urandom), 18'($urandom)};
        tick();
        checks++; if (obs_ready !== 3'b100) begin failures++; $display("FAIL rr_prime: got %b exp 100", obs_ready); end
        bus.req_valid = 3'b111;
        for (int r = 0; r < 3; r++) wait_c[r] = 0;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] want;
            want = 3'b001 << (i % 3);
            tick();
            checks++; if (obs_ready !== want || obs_ready !== exp_ready) begin failures++; $display("FAIL rr_order step %0d: got %b exp %b", i, obs_ready, want); end
            for (int r = 0; r < 3; r++) begin
                if (obs_ready[r]) begin
                    if (wait_c[r] > max_wait) max_wait = wait_c[r];
                    wait_c[r] = 0;
                    bus.req_data_flat = (bus.req_data_flat & ~(54'h3FFFF << (18 * r)))
                                        | (54'(18'($urandom)) << (18 * r));
                end else begin
                    wait_c[r]++;
                end
            end
        end
        bus.req_valid = 3'b000;
        checks++; if (max_wait > 2) begin failures++; $display("FAIL rr_wait: got %0d exp <=2", max_wait); end
        tick();
        checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL rr_dirty: got %b exp 1", dirty); end
    endtask

    task automatic test_commit_hold();
        int s = $urandom_range(0, 14);
        logic [17:0] d = 18'($urandom);
        set_line(479);
        tick();
        bus.req_valid = 3'b010;
        bus.req_slot_flat = 12'(s << 4);
        bus.req_data_flat = 54'(d) << 18;
        tick();
        checks++; if (obs_ready !== 3'b000) begin failures++; $display("FAIL hold_commit_ready: got %b exp 000", obs_ready); end
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL hold_tick: got %b exp 1", frame_tick); end
        tick();
        bus.req_valid = 3'b000;
        checks++; if (obs_ready !== 3'b010) begin failures++; $display("FAIL hold_next_ready: got %b exp 010", obs_ready); end
        checks++; if (live_slot(s) === d && m_live[s] !== d) begin failures++; $display("FAIL hold_early: got %h before next commit", live_slot(s)); end
        set_line(479);
        tick();
        tick();
        checks++; if (live_slot(s) !== d) begin failures++; $display("FAIL hold_commit slot %0d: got %h exp %h", s, live_slot(s), d); end
        checks++; if (slots_flat !== pack_live()) begin failures++; $display("FAIL hold_slots: got %h exp %h", slots_flat, pack_live()); end
    endtask

    task automatic test_slot15();
        int r = $urandom_range(0, 2);
        logic [269:0] snap;
        set_line(50);
        snap = slots_flat;
        bus.req_valid = 3'(1 << r);
        bus.req_slot_flat = 12'hFFF;
        bus.req_data_flat = 54'(18'h00001) << (18 * r);
        tick();
        bus.req_valid = 3'b000;
        checks++; if (obs_ready !== 3'(1 << r)) begin failures++; $display("FAIL s15_ready: got %b exp %b", obs_ready, 3'(1 << r)); end
        checks++; if (slot_err !== 1'b1) begin failures++; $display("FAIL s15_err: got %b exp 1", slot_err); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL s15_dirty: got %b exp 0", dirty); end
        set_line(479);
        repeat (3) tick();
        checks++; if (slots_flat !== snap) begin failures++; $display("FAIL s15_live: got %h exp %h", slots_flat, snap); end
        checks++; if (slot_err !== 1'b1) begin failures++; $display("FAIL s15_sticky: got %b exp 1", slot_err); end
    endtask

    task automatic test_clear_commit();
        logic [17:0] d = 18'($urandom);
        set_line(200);
        bus.req_valid = 3'b001;
        bus.req_slot_flat = 12'h005;
        bus.req_data_flat = 54'(d);
        tick();
        bus.req_valid = 3'b000;
        set_line(479);
        tick();
        clear_all = 1'b1;
        bus.req_valid = 3'b100;
        bus.req_slot_flat = 12'h700;
        tick();
        clear_all = 1'b0;
        bus.req_valid = 3'b000;
        checks++; if (obs_ready !== 3'b000) begin failures++; $display("FAIL clr_ready: got %b exp 000", obs_ready); end
        checks++; if (live_slot(5) !== d) begin failures++; $display("FAIL clr_live5: got %h exp %h", live_slot(5), d); end
        checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL clr_dirty: got %b exp 1", dirty); end
        set_line(479);
        repeat (2) tick();
        checks++; if (slots_flat !== all_unused) begin failures++; $display("FAIL clr_next_commit: got %h exp %h", slots_flat, all_unused); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 3; r++) begin
                bit v = bus.req_valid[r];
                if (!v || obs_ready[r]) begin
                    v = ($urandom_range(0, 1) == 1);
                    bus.req_slot_flat = (bus.req_slot_flat & ~(12'hF << (4 * r)))
                                        | (12'($urandom_range(0, 15)) << (4 * r));
                    bus.req_data_flat = (bus.req_data_flat & ~(54'h3FFFF << (18 * r)))
                                        | (54'(18'($urandom)) << (18 * r));
                end else if ($urandom_range(0, 9) == 0) begin
                    v = 0;
                end
                bus.req_valid[r] = v;
            end
            clear_all = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) set_line(470 + $urandom_range(0, 9));
            tick();
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc %0d: got %b exp %b", c, obs_ready, exp_ready); end
            checks++; if (slots_flat !== pack_live()) begin failures++; $display("FAIL rnd_slots cyc %0d: got %h exp %h", c, slots_flat, pack_live()); end
            checks++; if (frame_tick !== m_tick) begin failures++; $display("FAIL rnd_tick cyc %0d: got %b exp %b", c, frame_tick, m_tick); end
            checks++; if (dirty !== m_dirty) begin failures++; $display("FAIL rnd_dirty cyc %0d: got %b exp %b", c, dirty, m_dirty); end
            checks++; if (slot_err !== m_err) begin failures++; $display("FAIL rnd_err cyc %0d: got %b exp %b", c, slot_err, m_err); end
        end
        clear_all = 1'b0;
        bus.req_valid = 3'b000;
    endtask

    task automatic test_async_reset();
        set_line(100);
        bus.req_valid = 3'b001;
        bus.req_slot_flat = 12'h000;
        bus.req_data_flat = 54'(18'h12345);
        tick();
        bus.req_valid = 3'b111;
        #7;
        reset_n = 1'b0;
        #1;
        checks++; if (slots_flat !== all_unused) begin failures++; $display("FAIL areset_slots: got %h exp %h", slots_flat, all_unused); end
        checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL areset_dirty: got %b exp 0", dirty); end
        checks++; if (slot_err !== 1'b0) begin failures++; $display("FAIL areset_err: got %b exp 0", slot_err); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL areset_tick: got %b exp 0", frame_tick); end
        checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL areset_ready: got %b exp 000", bus.req_ready); end
        bus.req_valid = 3'b000;
        set_line(0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_line(479);
        repeat (2) tick();
        checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL areset_frame: got %b exp 1", frame_tick); end
        checks++; if (slots_flat !== all_unused) begin failures++; $display("FAIL areset_discard: got %h exp %h", slots_flat, all_unused); end
    endtask

    initial begin
        all_unused = '0;
        for (int k = 0; k < 15; k++) all_unused = all_unused | (270'(UNUSED) << (18 * k));
        obs_ready = '0;
        exp_ready = '0;
        test_reset();
        @(posedge clk);
        #1;
        test_idle_frames();
        test_single_write();
        test_round_robin();
        test_commit_hold();
        test_slot15();
        test_clear_commit();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
